// File: rtl/line_burst_memory.sv
// line_burst_memory
//   Single-port word memory that moves whole cache lines as bursts of
//   LINE_WORDS beats. Bursts start at the requested (critical) word and wrap
//   inside the line. Reads deliver data LATENCY cycles after acceptance.
//   Writes take one beat per cycle from acceptance, then wait LATENCY cycles
//   before completing.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset_n    : asynchronous active-low reset (memory array is not reset)
//   rd_mem     : line read request
//   wr_mem     : line write request
//   addr_mem   : word address {line, critical word offset}
//   data_in    : write beat data
//   data_out   : registered read beat data, holds when data_valid=0
//   data_valid : data_out carries a read beat (RBURST only)
//   ready_mem  : high in IDLE only
//   done       : one-cycle pulse on the last read beat / end of write wait
//   err        : one-cycle pulse after rd_mem and wr_mem were both high in IDLE
//   dbg_state  : current FSM state, for observation only
//
// Handshake: rd_mem/wr_mem are the request valids and ready_mem is the ready.
// A request is accepted on a rising edge where ready_mem=1 and exactly one of
// rd_mem/wr_mem is high. Requests seen while ready_mem=0 are dropped with no
// effect; the requester keeps its request asserted until it sees acceptance.
module line_burst_memory #(
  parameter int    AWIDTH     = 9,
  parameter int    DWIDTH     = 32,
  parameter int    LINE_WORDS = 4,
  parameter int    LATENCY    = 2,
  parameter string INIT_FILE  = ""
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_mem,
  input  logic              wr_mem,
  input  logic [AWIDTH-1:0] addr_mem,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic              data_valid,
  output logic              ready_mem,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  localparam int OFFW  = $clog2(LINE_WORDS);
  localparam int LINEW = AWIDTH - OFFW;
  localparam logic [OFFW-1:0] BEAT_LAST = OFFW'(LINE_WORDS - 1);
  localparam logic [3:0]      LAT_LAST  = 4'(LATENCY - 1);
  localparam logic [3:0]      LAT_DONE  = 4'(LATENCY);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RWAIT  = 3'd1,
    RBURST = 3'd2,
    WBURST = 3'd3,
    WWAIT  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [LINEW-1:0]  line_q, line_d;
  logic [OFFW-1:0]   off0_q, off0_d;   // critical word offset
  logic [OFFW-1:0]   beat_q, beat_d;   // beat index within the burst
  logic [3:0]        lat_q, lat_d;
  logic              err_q, err_d;
  logic [DWIDTH-1:0] data_out_q;

  logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];

  logic              mem_we;
  logic [AWIDTH-1:0] mem_waddr;
  logic              rd_load;
  logic [AWIDTH-1:0] mem_raddr;
  logic [OFFW-1:0]   cur_off;
  logic [OFFW-1:0]   next_off;

  // Offsets are OFFW bits wide, so the addition wraps inside the line and
  // never carries into the line bits (this covers the top line of memory).
  assign cur_off  = off0_q + beat_q;
  assign next_off = cur_off + OFFW'(1);

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    off0_d    = off0_q;
    beat_d    = beat_q;
    lat_d     = lat_q;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = {line_q, cur_off};
    rd_load   = 1'b0;
    mem_raddr = {line_q, cur_off};
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_mem && wr_mem) begin
          err_d = 1'b1;
        end else if (rd_mem) begin
          state_d = RWAIT;
          line_d  = addr_mem[AWIDTH-1:OFFW];
          off0_d  = addr_mem[OFFW-1:0];
          beat_d  = '0;
          lat_d   = '0;
        end else if (wr_mem) begin
          // Beat 0 is written on the accept edge itself.
          state_d   = WBURST;
          line_d    = addr_mem[AWIDTH-1:OFFW];
          off0_d    = addr_mem[OFFW-1:0];
          beat_d    = OFFW'(1);
          mem_we    = 1'b1;
          mem_waddr = addr_mem;
        end
      end
      RWAIT: begin
        // The last wait cycle fetches beat 0 so it is on data_out exactly
        // LATENCY edges after acceptance.
        if (lat_q == LAT_LAST) begin
          state_d = RBURST;
          lat_d   = '0;
          rd_load = 1'b1;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      RBURST: begin
        if (beat_q == BEAT_LAST) begin
          done    = 1'b1;
          state_d = IDLE;
          beat_d  = '0;
        end else begin
          beat_d    = beat_q + OFFW'(1);
          rd_load   = 1'b1;
          mem_raddr = {line_q, next_off};
        end
      end
      WBURST: begin
        mem_we = 1'b1;
        if (beat_q == BEAT_LAST) begin
          state_d = WWAIT;
          beat_d  = '0;
          lat_d   = '0;
        end else begin
          beat_d = beat_q + OFFW'(1);
        end
      end
      WWAIT: begin
        // LATENCY wait cycles followed by one completion cycle.
        if (lat_q == LAT_DONE) begin
          done    = 1'b1;
          state_d = IDLE;
          lat_d   = '0;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      line_q     <= '0;
      off0_q     <= '0;
      beat_q     <= '0;
      lat_q      <= '0;
      err_q      <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      off0_q  <= off0_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      err_q   <= err_d;
      if (rd_load) data_out_q <= mem[mem_raddr];
    end
  end

  // Array has no reset; writes are blocked while reset is held so an
  // in-flight write is abandoned and earlier beats survive.
  always_ff @(posedge clk) begin
    if (mem_we && reset_n) mem[mem_waddr] <= data_in;
  end

  assign data_out   = data_out_q;
  assign data_valid = (state_q == RBURST);
  assign ready_mem  = (state_q == IDLE);
  assign err        = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_line_burst_memory.sv
module tb_line_burst_memory;

  localparam int AW  = 9;
  localparam int DW  = 32;
  localparam int LW  = 4;
  localparam int LAT = 2;

  typedef logic [LW-1:0][DW-1:0] line_t;

  typedef struct packed {
    logic          is_wr;
    logic [AW-1:0] addr;
    line_t         beats;   // write data, or expected read beats
  } vec_t;

  // clock / reset
  logic          clk = 1'b0;
  logic          reset_n;
  logic          rd_mem, wr_mem;
  logic [AW-1:0] addr_mem;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          data_valid, ready_mem, done, err;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  line_burst_memory #(
    .AWIDTH(AW), .DWIDTH(DW), .LINE_WORDS(LW), .LATENCY(LAT), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset_n(reset_n), .rd_mem(rd_mem), .wr_mem(wr_mem),
    .addr_mem(addr_mem), .data_in(data_in), .data_out(data_out),
    .data_valid(data_valid), .ready_mem(ready_mem), .done(done), .err(err),
    .dbg_state(dbg_state)
  );

  // scoreboard / reference model
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] model_mem [1<<AW];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int word_addr(input logic [AW-1:0] a, input int k);
    int base;
    base = (int'(a) / LW) * LW;
    return base + ((int'(a) % LW) + k) % LW;
  endfunction

  function automatic line_t model_line(input logic [AW-1:0] a);
    line_t r;
    for (int k = 0; k < LW; k++) r[k] = model_mem[word_addr(a, k)];
    return r;
  endfunction

  function automatic vec_t mk(input logic w, input logic [AW-1:0] a,
                              input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                              input logic [DW-1:0] b2, input logic [DW-1:0] b3);
    vec_t v;
    v.is_wr = w; v.addr = a;
    v.beats[0] = b0; v.beats[1] = b1; v.beats[2] = b2; v.beats[3] = b3;
    return v;
  endfunction

  // driver tasks: always entered and left aligned to a falling edge
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready_mem && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check({tag, "_ready_timeout"}, 64'(ready_mem), 64'd1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input line_t d, input string tag);
    int n;
    wait_ready(tag);
    wr_mem = 1'b1; addr_mem = a; data_in = d[0];
    for (int k = 1; k < LW; k++) begin
      @(negedge clk);
      if (k == 1) check({tag, "_busy"}, 64'(ready_mem), 64'd0);
      wr_mem = 1'b0; addr_mem = AW'($urandom); data_in = d[k];
    end
    @(negedge clk);
    data_in = $urandom;
    n = 0;
    while (!done && n < LAT + 6) begin @(negedge clk); n++; end
    check({tag, "_wr_done_lat"}, 64'(n), 64'(LAT));
    @(negedge clk);
    check({tag, "_wr_ready_after"}, {62'd0, ready_mem, done}, 64'b10);
    for (int k = 0; k < LW; k++) model_mem[word_addr(a, k)] = d[k];
  endtask

  task automatic do_read(input logic [AW-1:0] a, input line_t exp,
                         input bit inject_wr, input string tag);
    int n;
    wait_ready(tag);
    rd_mem = 1'b1; addr_mem = a;
    @(negedge clk);
    rd_mem = 1'b0; addr_mem = AW'($urandom);
    n = 0;
    while (!data_valid && n < LAT + 6) begin @(negedge clk); n++; end
    check({tag, "_rd_first_lat"}, 64'(n), 64'(LAT));
    for (int k = 0; k < LW; k++) begin
      check({tag, "_rd_valid"}, {61'd0, data_valid, ready_mem, done},
            {61'd0, 1'b1, 1'b0, (k == LW - 1)});
      check({tag, $sformatf("_rd_beat%0d", k)}, 64'(data_out), 64'(exp[k]));
      wr_mem = inject_wr && (k == 1);
      if (inject_wr && k == 1) begin addr_mem = a; data_in = $urandom; end
      @(negedge clk);
    end
    wr_mem = 1'b0;
    check({tag, "_rd_end"}, {61'd0, data_valid, ready_mem, done}, {61'd0, 3'b010});
    check({tag, "_rd_hold"}, 64'(data_out), 64'(exp[LW-1]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rst_ctrl"}, {60'd0, ready_mem, data_valid, done, err}, {60'd0, 4'b1000});
    check({tag, "_rst_data"}, 64'(data_out), 64'd0);
  endtask

  vec_t vecs[10];

  initial begin
    line_t d;
    logic [AW-1:0] a;
    int vld_seen;

    reset_n = 1'b0; rd_mem = 1'b0; wr_mem = 1'b0; addr_mem = '0; data_in = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("init");
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_ready", {62'd0, ready_mem, err}, 64'b10);

    // Fill all lines so every later read has a known expectation.
    for (int ln = 0; ln < (1 << AW) / LW; ln++) begin
      for (int k = 0; k < LW; k++) d[k] = $urandom;
      do_write(AW'(ln * LW + $urandom_range(0, LW - 1)), d, "fill");
    end

    // directed vectors
    vecs[0] = mk(1'b1, 9'h010, 32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hA333_3333);
    vecs[1] = mk(1'b0, 9'h010, 32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hA333_3333);
    vecs[2] = mk(1'b0, 9'h012, 32'hA222_2222, 32'hA333_3333, 32'hA000_0000, 32'hA111_1111);
    vecs[3] = mk(1'b0, 9'h013, 32'hA333_3333, 32'hA000_0000, 32'hA111_1111, 32'hA222_2222);
    vecs[4] = mk(1'b1, 9'h1FE, 32'hB000_0000, 32'hB111_1111, 32'hB222_2222, 32'hB333_3333);
    vecs[5] = mk(1'b0, 9'h1FE, 32'hB000_0000, 32'hB111_1111, 32'hB222_2222, 32'hB333_3333);
    vecs[6] = mk(1'b0, 9'h1FC, 32'hB222_2222, 32'hB333_3333, 32'hB000_0000, 32'hB111_1111);
    vecs[7] = mk(1'b1, 9'h00D, 32'hD000_0000, 32'hD111_1111, 32'hD222_2222, 32'hD333_3333);
    vecs[8] = mk(1'b0, 9'h00C, 32'hD333_3333, 32'hD000_0000, 32'hD111_1111, 32'hD222_2222);
    vecs[9] = mk(1'b0, 9'h011, 32'hA111_1111, 32'hA222_2222, 32'hA333_3333, 32'hA000_0000);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].beats, $sformatf("vec%0d", i));
      else do_read(vecs[i].addr, vecs[i].beats, 1'b0, $sformatf("vec%0d", i));
    end

    // top-line wrap must not spill into line 0
    do_read(9'h000, model_line(9'h000), 1'b0, "line0_untouched");

    // rd and wr together in IDLE
    rd_mem = 1'b1; wr_mem = 1'b1; addr_mem = 9'h010; data_in = 32'hDEAD_BEEF;
    @(negedge clk);
    rd_mem = 1'b0; wr_mem = 1'b0;
    check("both_err", {61'd0, err, ready_mem, data_valid}, {61'd0, 3'b110});
    @(negedge clk);
    check("both_err_pulse", 64'(err), 64'd0);
    do_read(9'h010, model_line(9'h010), 1'b0, "both_nochange");

    // write request during a read burst is ignored
    do_read(9'h010, model_line(9'h010), 1'b1, "wr_in_rburst");
    do_read(9'h010, model_line(9'h010), 1'b0, "wr_in_rburst_after");

    // reset after beat 1 of a write
    wait_ready("rst_wr");
    wr_mem = 1'b1; addr_mem = 9'h020; data_in = 32'hC000_0000;
    @(negedge clk);
    wr_mem = 1'b0; data_in = 32'hC111_1111;
    @(negedge clk);
    data_in = 32'hC222_2222;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_wr");
    @(negedge clk);
    reset_n = 1'b1;
    model_mem[9'h020] = 32'hC000_0000;
    model_mem[9'h021] = 32'hC111_1111;
    @(negedge clk);
    data_in = 32'h0;
    do_read(9'h020, model_line(9'h020), 1'b0, "rst_wr_read");

    // reset during a read burst
    wait_ready("rst_rd");
    rd_mem = 1'b1; addr_mem = 9'h030;
    @(negedge clk);
    rd_mem = 1'b0;
    repeat (LAT) @(negedge clk);
    check("rst_rd_started", 64'(data_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_rd");
    @(negedge clk);
    reset_n = 1'b1;
    vld_seen = 0;
    repeat (8) begin @(negedge clk); if (data_valid) vld_seen++; end
    check("rst_rd_no_valid", 64'(vld_seen), 64'd0);

    // random traffic against the model
    for (int i = 0; i < 80; i++) begin
      a = AW'($urandom_range(0, (1 << AW) - 1));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < LW; k++) d[k] = $urandom;
        do_write(a, d, "rnd");
      end else begin
        do_read(a, model_line(a), 1'b0, "rnd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
